// File: rtl/clk_ratio_mon_pkg.sv
// Shared types and defaults for the divided-clock ratio monitor.
package clk_ratio_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam int CNT_W_DEF    = 8;
    localparam int LOCK_CNT_DEF = 4;
    localparam int MATCH_W      = 4;

endpackage

// File: rtl/clk_ratio_mon_edge.sv
// Sampling and rising-edge detect for the monitored divided clock.
// CLK_RATIO_MON_SYNC_EN adds a two-flop synchronizer in front of the sampler.
module clk_ratio_mon_edge
    import clk_ratio_mon_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o
);

    logic din;
    logic smp_q;
    logic prev_q;

`ifdef CLK_RATIO_MON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign din = sync_q[1];
`else
    assign din = d_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smp_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            smp_q  <= din;
            prev_q <= smp_q;
        end
    end

    assign lvl_o  = smp_q;
    assign rise_o = smp_q & ~prev_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures period/high time of a divided clock, tracks lock, flags errors.
// Build option: CLK_RATIO_MON_SYNC_EN (synchronizer on div_in).
module clk_ratio_monitor
    import clk_ratio_mon_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_period,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             err,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   CNT_PRE   = CNT_MAX - CNT_ONE;
    localparam logic [MATCH_W-1:0] MATCH_ONE = MATCH_W'(1);
    localparam logic [MATCH_W-1:0] LOCK_TGT  = MATCH_W'(LOCK_CNT);

    logic lvl;
    logic rise;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   hi_q, hi_d;
    logic [MATCH_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   high_q, high_d;
    logic               mv_q, mv_d;
    logic               err_q, err_d;
    logic               to_q, to_d;

    logic sat;
    logic match;
    logic pub;
    logic err_set;

    clk_ratio_mon_edge u_edge (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (div_in),
        .lvl_o  (lvl),
        .rise_o (rise)
    );

    // Saturation fires on the step into CNT_MAX, then the counter parks there
    assign sat   = ~rise & (cnt_q == CNT_PRE);
    assign match = (cnt_q == exp_period);

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        if (rise) begin
            cnt_d = CNT_ONE;
            hi_d  = CNT_ONE;
        end else begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            if (lvl && hi_q != CNT_MAX) hi_d = hi_q + CNT_ONE;
        end
    end

    always_comb begin
        state_d = state_q;
        mcnt_d  = mcnt_q;
        pub     = 1'b0;
        err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                mcnt_d = '0;
                if (rise) state_d = MEASURE;
            end
            MEASURE: begin
                if (rise) begin
                    pub = 1'b1;
                    if (match) begin
                        mcnt_d = mcnt_q + MATCH_ONE;
                        if (mcnt_q + MATCH_ONE == LOCK_TGT) state_d = LOCKED;
                    end else begin
                        mcnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (rise) begin
                    pub = 1'b1;
                    if (!match) begin
                        err_set = 1'b1;
                        mcnt_d  = '0;
                        state_d = MEASURE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (sat) begin
            state_d = IDLE;
            mcnt_d  = '0;
        end
    end

    always_comb begin
        period_d = pub ? cnt_q : period_q;
        high_d   = pub ? hi_q : high_q;
        mv_d     = pub;
        err_d    = err_q;
        to_d     = to_q;
        if (clr) begin
            err_d = 1'b0;
            to_d  = 1'b0;
        end
        if (err_set) err_d = 1'b1;
        if (sat) to_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            mcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            mv_q     <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            mcnt_q   <= mcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            mv_q     <= mv_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign locked     = (state_q == LOCKED);
    assign err        = err_q;
    assign timeout    = to_q;

endmodule
